// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package fifo_arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    // Requester indices are carried at a fixed width that covers the largest
    // supported requester count, so helpers here need no module parameters.
    localparam int NREQ_MAX = 8;
    localparam int IDX_W    = 3;

    // beat_cnt width for the default burst length; instances with another
    // MAXBURST size their counter with beat_cnt_w().
    localparam int MAXBURST_DEF   = 4;
    localparam int BEAT_CNT_W_DEF = $clog2(MAXBURST_DEF + 1);

    function automatic int beat_cnt_w(input int maxburst);
        return $clog2(maxburst + 1);
    endfunction

    function automatic logic [NREQ_MAX-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NREQ_MAX-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Next index modulo n (n = number of requesters actually present).
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx, input int n);
        if (int'(idx) >= n - 1) begin
            return '0;
        end
        return idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set bit of (req & ~mask) searching upward from start, wrapping.
// Latency: purely combinational.
// Backpressure: none; pick_vld=0 when no candidate is present.
// Ports: req/mask (NREQ), start index -> pick_vld, pick_idx.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  mask,
    input  logic [IDX_W-1:0] start,
    output logic             pick_vld,
    output logic [IDX_W-1:0] pick_idx
);

    logic [NREQ_MAX-1:0] cand;
    logic [IDX_W:0]      pos;

    assign cand = NREQ_MAX'(req & ~mask);

    // Walk offsets from the far end back toward start so the candidate
    // closest to start is the last one written and therefore wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        pos      = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            pos = {1'b0, start} + (IDX_W + 1)'(i);
            if (pos >= (IDX_W + 1)'(NREQ)) begin
                pos = pos - (IDX_W + 1)'(NREQ);
            end
            if (cand[pos[IDX_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin sharing of the async FIFO write port among NREQ requesters, bursts of up to MAXBURST beats.
// Latency: req to gnt 1 cycle; winc/wdata/ack are combinational from gnt, req and wfull.
// Backpressure: wfull stalls the owner's beat (no write, no ack); ownership is held through the stall.
// Ports: clk, rst (async, active-high); req/data per requester; ack, gnt one-hot;
//        wfull in, winc/wdata to the FIFO; busy while a requester owns the port.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int dw       = 16,
    parameter int MAXBURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*dw-1:0]  data,
    output logic [NREQ-1:0]     ack,
    output logic [NREQ-1:0]     gnt,
    input  logic                wfull,
    output logic                winc,
    output logic [dw-1:0]       wdata,
    output logic                busy
);

    localparam int BCW = beat_cnt_w(MAXBURST);

    arb_state_t       state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] rr_ptr;
    logic [BCW-1:0]   beat_cnt;

    logic [NREQ_MAX-1:0] req_x;
    logic [NREQ-1:0]     owner_oh;
    logic                owner_req;
    logic                burst_end;
    logic                release_own;

    logic [NREQ-1:0]  pick_mask;
    logic [IDX_W-1:0] pick_start;
    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;

    assign req_x     = NREQ_MAX'(req);
    assign owner_req = req_x[owner];
    assign owner_oh  = NREQ'(onehot(owner));

    assign busy      = (state == GRANT);
    assign winc      = busy & owner_req & ~wfull;
    assign ack       = winc ? owner_oh : '0;

    // The burst limit only counts real writes; a stall on wfull never ends a
    // burst, only the owner dropping req does.
    assign burst_end   = winc & (beat_cnt == BCW'(MAXBURST - 1));
    assign release_own = busy & (burst_end | ~owner_req);

    // One picker serves both paths. In IDLE the search starts after the last
    // released owner; on release it starts after the current owner, and since
    // rr_ptr is loaded with that owner the two agree. When the owner hits the
    // burst limit with nobody else waiting, the wrapped search lands back on
    // the owner, which is exactly the regrant case.
    assign pick_start = busy ? wrap_inc(owner, NREQ) : wrap_inc(rr_ptr, NREQ);
    assign pick_mask  = (busy & ~owner_req) ? owner_oh : '0;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req      (req),
        .mask     (pick_mask),
        .start    (pick_start),
        .pick_vld (pick_vld),
        .pick_idx (pick_idx)
    );

    always_comb begin
        wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winc && (owner == IDX_W'(i))) begin
                wdata = data[i*dw +: dw];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            beat_cnt <= '0;
            rr_ptr   <= IDX_W'(NREQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state    <= GRANT;
                        owner    <= pick_idx;
                        gnt      <= NREQ'(onehot(pick_idx));
                        beat_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (release_own) begin
                        rr_ptr   <= owner;
                        beat_cnt <= '0;
                        if (pick_vld) begin
                            // Zero-bubble handover (or regrant of the same owner).
                            owner <= pick_idx;
                            gnt   <= NREQ'(onehot(pick_idx));
                        end else begin
                            state <= IDLE;
                            gnt   <= '0;
                        end
                    end else if (winc) begin
                        beat_cnt <= beat_cnt + BCW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    localparam int NREQ     = 4;
    localparam int DW       = 16;
    localparam int MAXBURST = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*DW-1:0]  data = '0;
    logic [NREQ-1:0]     ack;
    logic [NREQ-1:0]     gnt;
    logic                wfull = 1'b0;
    logic                winc;
    logic [DW-1:0]       wdata;
    logic                busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [NREQ-1:0] last_ack = '0;
    logic [DW-1:0]   exp_q[$];
    logic [DW-1:0]   got_q[$];

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NREQ     (NREQ),
        .dw       (DW),
        .MAXBURST (MAXBURST)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .data  (data),
        .ack   (ack),
        .gnt   (gnt),
        .wfull (wfull),
        .winc  (winc),
        .wdata (wdata),
        .busy  (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // First requester with a pending request, searching upward from start.
    function automatic int rr_search(input logic [NREQ-1:0] r, input int start);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(start + k) % NREQ]) return (start + k) % NREQ;
        end
        return -1;
    endfunction

    // Behavioural model: who owns the port, how many beats it has been given,
    // and who was released last. Checked and advanced once per cycle.
    initial begin
        bit              m_busy;
        int              m_owner;
        int              m_beats;
        int              m_last;
        int              p;
        bit              e_winc;
        bit              dropped;
        logic [NREQ-1:0] e_gnt;
        logic [NREQ-1:0] r;
        logic [DW-1:0]   e_wdata;
        m_busy  = 0;
        m_owner = 0;
        m_beats = 0;
        m_last  = NREQ - 1;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_busy  = 0;
                m_owner = 0;
                m_beats = 0;
                m_last  = NREQ - 1;
            end else begin
                e_winc  = m_busy && req[m_owner] && !wfull;
                e_gnt   = m_busy ? (NREQ'(1) << m_owner) : '0;
                e_wdata = e_winc ? data[m_owner*DW +: DW] : '0;
                chk("m_gnt",   32'(gnt),   32'(e_gnt));
                chk("m_busy",  32'(busy),  32'(m_busy));
                chk("m_winc",  32'(winc),  32'(e_winc));
                chk("m_ack",   32'(ack),   e_winc ? 32'(e_gnt) : 32'd0);
                chk("m_wdata", 32'(wdata), 32'(e_wdata));
                if (e_winc) exp_q.push_back(e_wdata);
                if (winc)   got_q.push_back(wdata);

                if (!m_busy) begin
                    p = rr_search(req, (m_last + 1) % NREQ);
                    if (p >= 0) begin
                        m_busy  = 1;
                        m_owner = p;
                        m_beats = 0;
                    end
                end else begin
                    dropped = !req[m_owner];
                    if (e_winc) m_beats++;
                    if (dropped || m_beats == MAXBURST) begin
                        m_last = m_owner;
                        r = req;
                        if (dropped) r[m_owner] = 1'b0;
                        p = rr_search(r, (m_owner + 1) % NREQ);
                        m_beats = 0;
                        if (p >= 0) m_owner = p;
                        else        m_busy  = 0;
                    end
                end
            end
            last_ack = ack;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req   = '0;
        wfull = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < NREQ; i++) data[i*DW +: DW] = 16'hA000 + 16'(i);

        // Reset state
        do_reset();
        #2;
        chk("rst_gnt",   32'(gnt),   32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_winc",  32'(winc),  32'd0);
        chk("rst_ack",   32'(ack),   32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);

        // Single requester: 1-cycle arbitration, then continuous writes across regrant
        tick();
        req = 4'b0001;
        #2;
        chk("t1_idle_gnt", 32'(gnt), 32'd0);
        tick();
        #2;
        chk("t1_gnt", 32'(gnt), 32'h1);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (winc && ack == 4'b0001 && wdata == 16'hA000) cnt++;
            tick();
            #2;
        end
        chk("t1_beats8", 32'(cnt), 32'd8);

        // All requesting: order 0,1,2,3,0 with 4 beats each, no bubble
        do_reset();
        tick();
        req = 4'b1111;
        tick();
        for (int k = 0; k < 20; k++) begin
            #2;
            chk("t2_winc", 32'(winc), 32'd1);
            chk("t2_ack",  32'(ack),  32'(4'b0001 << ((k / 4) % 4)));
            tick();
        end

        // Requester 2 stalls on wfull after beat 2, competitor 0 waits
        do_reset();
        tick();
        req = 4'b0100;
        tick();
        #2;
        chk("t3_beat1", 32'(ack), 32'h4);
        tick();
        #2;
        chk("t3_beat2", 32'(ack), 32'h4);
        tick();
        wfull = 1'b1;
        req   = 4'b0101;
        for (int k = 0; k < 5; k++) begin
            #2;
            chk("t3_stall_winc", 32'(winc), 32'd0);
            chk("t3_stall_gnt",  32'(gnt),  32'h4);
            tick();
        end
        wfull = 1'b0;
        #2;
        chk("t3_beat3", 32'(ack), 32'h4);
        tick();
        #2;
        chk("t3_beat4", 32'(ack), 32'h4);
        tick();
        #2;
        chk("t3_handover", 32'(gnt), 32'h1);

        // Requester 1 drops after one beat, requester 3 pending
        do_reset();
        tick();
        req = 4'b1010;
        tick();
        #2;
        chk("t4_gnt1", 32'(gnt),   32'h2);
        chk("t4_ack1", 32'(ack),   32'h2);
        chk("t4_wd1",  32'(wdata), 32'hA001);
        tick();
        req = 4'b1000;
        #2;
        chk("t4_rel_ack", 32'(ack), 32'd0);
        tick();
        #2;
        chk("t4_gnt3", 32'(gnt),   32'h8);
        chk("t4_wd3",  32'(wdata), 32'hA003);
        for (int k = 0; k < 3; k++) begin
            tick();
            #2;
            chk("t4_no_ack1", 32'(ack[1]), 32'd0);
        end

        // Async reset while requester 3 owns at beat 2
        do_reset();
        tick();
        req = 4'b1000;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_gnt",  32'(gnt),  32'd0);
        chk("t5_rst_winc", 32'(winc), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        req = 4'b1001;
        tick();
        rst = 1'b0;
        #2;
        chk("t5_idle_gnt", 32'(gnt), 32'd0);
        tick();
        #2;
        chk("t5_first_gnt", 32'(gnt), 32'h1);

        // Randomized traffic: requesters hold req/data until acked
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && last_ack[i]) begin
                    data[i*DW +: DW] = 16'($urandom);
                    if ($urandom_range(2) == 0) req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(3) == 0) begin
                    data[i*DW +: DW] = 16'($urandom);
                    req[i] = 1'b1;
                end
            end
            wfull = ($urandom_range(4) == 0);
        end
        tick();
        req   = '0;
        wfull = 1'b0;
        tick();
        tick();

        // Beats written to the FIFO, in order, against the model's stream
        chk("sb_len", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            chk("sb_data", 32'(got_q[i]), 32'(exp_q[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
